mcse_ahb_bus_bridge: RTL and testbench

// AHB requester bridge behind the MCSE control unit: arbitrates the bootControl and fw bus clients.

---
 rtl/mcse_ahb_bus_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_mcse_ahb_bus_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcse_ahb_bus_bridge.sv
// MCSE AHB requester bridge: arbitrates the bootControl and fw clients and splits each
// wide payload request into a sequence of AHB SINGLE transfers.

module mcse_ahb_req_slot #(
  parameter int AW = 32,
  parameter int PS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [AW-1:0] addr,
  input  logic          rw,
  input  logic [PS-1:0] wdata,
  input  logic          clr,
  output logic          pending,
  output logic [AW-1:0] addr_q,
  output logic          rw_q,
  output logic [PS-1:0] wdata_q
);
  // A go is only taken while the slot is free; an active request holds its fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (go && !pending) begin
      pending <= 1'b1;
      addr_q  <= addr;
      rw_q    <= rw;
      wdata_q <= wdata;
    end
  end
endmodule

module mcse_ahb_bus_bridge #(
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_HRESP_WIDTH   = 2,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pTIMEOUT_CYCLES    = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bc_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bc_bus_addr,
  input  logic                          bc_bus_RW,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bc_bus_write,
  output logic                          bc_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bc_bus_rdData,
  output logic                          bc_bus_err,
  input  logic                          fw_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    fw_bus_addr,
  input  logic                          fw_bus_RW,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] fw_bus_write,
  output logic                          fw_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] fw_bus_rdData,
  output logic                          fw_bus_err,
  input  logic [pAHB_DATA_WIDTH-1:0]    I_hrdata,
  input  logic                          I_hready,
  input  logic [pAHB_HRESP_WIDTH-1:0]   I_hresp,
  output logic [pAHB_ADDR_WIDTH-1:0]    O_haddr,
  output logic [2:0]                    O_hburst,
  output logic                          O_hmastlock,
  output logic [3:0]                    O_hprot,
  output logic                          O_hnonsec,
  output logic [2:0]                    O_hsize,
  output logic [1:0]                    O_htrans,
  output logic [pAHB_DATA_WIDTH-1:0]    O_hwdata,
  output logic                          O_hwrite
);
  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int DW = pAHB_DATA_WIDTH;
  localparam int PS = pPAYLOAD_SIZE_BITS;
  localparam int NB = PS / DW;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(pTIMEOUT_CYCLES + 1);
  localparam logic [2:0]    HSIZE = 3'($clog2(DW / 8));
  localparam logic [AW-1:0] BSTEP = AW'(DW / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]         go_v, rw_v, clr_v, pend, rw_q;
  logic [1:0][AW-1:0] addr_v, addr_q;
  logic [1:0][PS-1:0] wdata_v, wdata_q;

  assign go_v    = {fw_bus_go, bc_bus_go};
  assign rw_v    = {fw_bus_RW, bc_bus_RW};
  assign addr_v  = {fw_bus_addr, bc_bus_addr};
  assign wdata_v = {fw_bus_write, bc_bus_write};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    mcse_ahb_req_slot #(.AW(AW), .PS(PS)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (go_v[i]),
      .addr    (addr_v[i]),
      .rw      (rw_v[i]),
      .wdata   (wdata_v[i]),
      .clr     (clr_v[i]),
      .pending (pend[i]),
      .addr_q  (addr_q[i]),
      .rw_q    (rw_q[i]),
      .wdata_q (wdata_q[i])
    );
  end

  logic          gnt;      // 0 = bc, 1 = fw
  logic          rr_fw;    // fw wins the next tie
  logic [BW-1:0] beat;
  logic          err_q;
  logic [PS-1:0] rd_buf;
  logic [TW-1:0] tmo_cnt;

  logic          grant, gnt_sel, beat_inc, capture, set_err, tmo_inc, tmo_clr;
  logic          tmo_hit, hresp_err, last_beat;
  logic [AW-1:0] cur_addr;
  logic          cur_rw;
  logic [PS-1:0] cur_wdata;

  assign cur_addr  = addr_q[gnt];
  assign cur_rw    = rw_q[gnt];
  assign cur_wdata = wdata_q[gnt];
  assign tmo_hit   = (tmo_cnt == TW'(pTIMEOUT_CYCLES - 1));
  assign hresp_err = (I_hresp == pAHB_HRESP_WIDTH'(1));
  assign last_beat = (beat == BW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_sel   = 1'b0;
    beat_inc  = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    tmo_inc   = 1'b0;
    tmo_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        tmo_clr = 1'b1;
        if (|pend) begin
          grant     = 1'b1;
          gnt_sel   = (&pend) ? rr_fw : pend[1];
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (I_hready) begin
          tmo_clr   = 1'b1;
          state_nxt = S_DATA;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_DATA: begin
        // ERROR is only honoured on its hready-high cycle, so the first ERROR cycle just waits.
        if (I_hready) begin
          tmo_clr = 1'b1;
          if (hresp_err) begin
            set_err   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            capture = !cur_rw;
            if (last_beat) begin
              state_nxt = S_DONE;
            end else begin
              beat_inc  = 1'b1;
              state_nxt = S_ADDR;
            end
          end
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= 1'b0;
      rr_fw   <= 1'b0;
      beat    <= '0;
      err_q   <= 1'b0;
      rd_buf  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (grant) begin
        gnt    <= gnt_sel;
        beat   <= '0;
        err_q  <= 1'b0;
        rd_buf <= '0;
      end
      if (beat_inc) beat <= beat + 1'b1;
      if (capture)  rd_buf[int'(beat)*DW +: DW] <= I_hrdata;
      if (set_err)  err_q <= 1'b1;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_DONE) rr_fw <= ~gnt;
    end
  end

  assign clr_v[0] = (state == S_DONE) && !gnt;
  assign clr_v[1] = (state == S_DONE) && gnt;

  assign bc_bus_done   = clr_v[0];
  assign fw_bus_done   = clr_v[1];
  assign bc_bus_rdData = clr_v[0] ? rd_buf : '0;
  assign fw_bus_rdData = clr_v[1] ? rd_buf : '0;
  assign bc_bus_err    = clr_v[0] & err_q;
  assign fw_bus_err    = clr_v[1] & err_q;

  assign O_hburst    = 3'b000;
  assign O_hmastlock = 1'b0;
  assign O_hnonsec   = 1'b0;
  assign O_htrans    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign O_haddr     = (state == S_ADDR) ? cur_addr + AW'(beat) * BSTEP : '0;
  assign O_hwrite    = (state == S_ADDR) && cur_rw;
  assign O_hsize     = (state == S_ADDR) ? HSIZE : 3'b000;
  assign O_hprot     = (state == S_ADDR) ? 4'b0011 : 4'b0000;
  assign O_hwdata    = (state == S_DATA && cur_rw) ? cur_wdata[int'(beat)*DW +: DW] : '0;
endmodule

// File: tb/tb_mcse_ahb_bus_bridge.sv
// Directed bench for mcse_ahb_bus_bridge with a small cycle-stepped AHB slave.

module tb_mcse_ahb_bus_bridge;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bc_bus_go = 1'b0, bc_bus_RW = 1'b0;
  logic [31:0]  bc_bus_addr = '0;
  logic [127:0] bc_bus_write = '0;
  logic         bc_bus_done, bc_bus_err;
  logic [127:0] bc_bus_rdData;
  logic         fw_bus_go = 1'b0, fw_bus_RW = 1'b0;
  logic [31:0]  fw_bus_addr = '0;
  logic [127:0] fw_bus_write = '0;
  logic         fw_bus_done, fw_bus_err;
  logic [127:0] fw_bus_rdData;
  logic [31:0]  I_hrdata = '0;
  logic         I_hready = 1'b1;
  logic [1:0]   I_hresp = '0;
  logic [31:0]  O_haddr;
  logic [2:0]   O_hburst, O_hsize;
  logic         O_hmastlock, O_hnonsec, O_hwrite;
  logic [3:0]   O_hprot;
  logic [1:0]   O_htrans;
  logic [31:0]  O_hwdata;

  mcse_ahb_bus_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .bc_bus_go(bc_bus_go), .bc_bus_addr(bc_bus_addr), .bc_bus_RW(bc_bus_RW),
    .bc_bus_write(bc_bus_write), .bc_bus_done(bc_bus_done), .bc_bus_rdData(bc_bus_rdData),
    .bc_bus_err(bc_bus_err),
    .fw_bus_go(fw_bus_go), .fw_bus_addr(fw_bus_addr), .fw_bus_RW(fw_bus_RW),
    .fw_bus_write(fw_bus_write), .fw_bus_done(fw_bus_done), .fw_bus_rdData(fw_bus_rdData),
    .fw_bus_err(fw_bus_err),
    .I_hrdata(I_hrdata), .I_hready(I_hready), .I_hresp(I_hresp),
    .O_haddr(O_haddr), .O_hburst(O_hburst), .O_hmastlock(O_hmastlock), .O_hprot(O_hprot),
    .O_hnonsec(O_hnonsec), .O_hsize(O_hsize), .O_htrans(O_htrans), .O_hwdata(O_hwdata),
    .O_hwrite(O_hwrite)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // slave model state and logs
  bit          dph = 0;
  int          dph_idx = 0;
  int          wcnt = 0;
  int          ws = 0;
  int          err_beat = -1;
  bit          stall = 0;
  logic [31:0] rd_val [4];
  int          n_ns = 0;
  logic [31:0] ns_addr [16];
  bit          ns_wr [16];
  logic [31:0] wd_log [4];

  bit           got_done = 0;
  int           done_cyc = 0;
  int           done_who = 0;
  logic [127:0] done_rd = '0;
  logic         done_err = 1'b0;

  localparam logic [127:0] WPAY = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] RPAY = 128'h0000000D_0000000C_0000000B_0000000A;

  task automatic clear_log();
    n_ns = 0;
    for (int k = 0; k < 4; k++) wd_log[k] = '0;
    for (int k = 0; k < 16; k++) begin ns_addr[k] = '0; ns_wr[k] = 0; end
  endtask

  task automatic step();
    @(posedge clk); #1;
    bc_bus_go = 1'b0;
    fw_bus_go = 1'b0;
    if (bc_bus_done || fw_bus_done) begin
      got_done = 1;
      done_cyc = cyc;
      done_who = fw_bus_done ? 1 : 0;
      done_rd  = fw_bus_done ? fw_bus_rdData : bc_bus_rdData;
      done_err = fw_bus_done ? fw_bus_err : bc_bus_err;
    end
    I_hrdata = 32'hDEAD_BEEF;
    I_hresp  = 2'b00;
    I_hready = 1'b1;
    if (O_htrans == 2'b10) begin
      if (n_ns < 16) begin ns_addr[n_ns] = O_haddr; ns_wr[n_ns] = O_hwrite; end
      n_ns++;
      if (stall) I_hready = 1'b0;
      else begin dph = 1; wcnt = 0; dph_idx = int'(O_haddr[3:2]); end
    end else if (dph) begin
      if (dph_idx == err_beat) begin
        I_hresp = 2'b01;
        if (wcnt == 0) begin I_hready = 1'b0; wcnt = 1; end
        else dph = 0;
      end else if (wcnt < ws) begin
        I_hready = 1'b0;
        wcnt++;
      end else begin
        I_hrdata = rd_val[dph_idx];
        wd_log[dph_idx] = O_hwdata;
        dph = 0;
      end
    end
  endtask

  task automatic run(input int budget, input string name);
    got_done = 0;
    for (int i = 0; i < budget && !got_done; i++) step();
    tests++;
    if (!got_done) begin
      fails++;
      $display("FAIL %s: no done within %0d cycles (got none, required one)", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (O_htrans !== 2'b00 || O_haddr !== 32'h0 || O_hwrite !== 1'b0) begin
      fails++; $display("FAIL reset_bus: htrans=%0h haddr=%0h hwrite=%0b, required 0/0/0", O_htrans, O_haddr, O_hwrite);
    end
    tests++;
    if (O_hprot !== 4'h0 || O_hsize !== 3'h0 || O_hwdata !== 32'h0) begin
      fails++; $display("FAIL reset_ctl: hprot=%0h hsize=%0h hwdata=%0h, required 0", O_hprot, O_hsize, O_hwdata);
    end
    tests++;
    if (O_hburst !== 3'h0 || O_hmastlock !== 1'b0 || O_hnonsec !== 1'b0) begin
      fails++; $display("FAIL reset_const: hburst=%0h mastlock=%0b nonsec=%0b, required 0", O_hburst, O_hmastlock, O_hnonsec);
    end
    tests++;
    if (bc_bus_done !== 1'b0 || fw_bus_done !== 1'b0 || bc_bus_err !== 1'b0 || bc_bus_rdData !== '0) begin
      fails++; $display("FAIL reset_client: bc_done=%0b fw_done=%0b bc_err=%0b, required 0", bc_bus_done, fw_bus_done, bc_bus_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic check_write_txn(input int g, input string name);
    logic [31:0] exp_wd [4];
    exp_wd[0] = 32'h11; exp_wd[1] = 32'h22; exp_wd[2] = 32'h33; exp_wd[3] = 32'h44;
    tests++;
    if (done_who !== 0 || done_cyc - g !== 10 || done_err !== 1'b0 || done_rd !== '0) begin
      fails++; $display("FAIL %s_done: who=%0d lat=%0d err=%0b rd=%0h, required 0/10/0/0", name, done_who, done_cyc - g, done_err, done_rd);
    end
    tests++;
    if (n_ns !== 4) begin fails++; $display("FAIL %s_nonseq: count=%0d, required 4", name, n_ns); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ns_addr[k] !== 32'h1000 + 32'(4 * k) || ns_wr[k] !== 1'b1 || wd_log[k] !== exp_wd[k]) begin
        fails++; $display("FAIL %s_beat%0d: addr=%0h wr=%0b wdata=%0h, required %0h/1/%0h", name, k, ns_addr[k], ns_wr[k], wd_log[k], 32'h1000 + 32'(4 * k), exp_wd[k]);
      end
    end
  endtask

  task automatic issue_bc_write();
    bc_bus_addr = 32'h1000; bc_bus_RW = 1'b1; bc_bus_write = WPAY; bc_bus_go = 1'b1;
  endtask

  task automatic issue_fw_read();
    fw_bus_addr = 32'h2000; fw_bus_RW = 1'b0; fw_bus_write = '1; fw_bus_go = 1'b1;
  endtask

  task automatic test_bc_write();
    int g;
    clear_log(); ws = 0;
    issue_bc_write(); g = cyc;
    run(40, "t1_wait");
    check_write_txn(g, "t1");
  endtask

  task automatic test_fw_read_wait();
    int g;
    clear_log(); ws = 2;
    rd_val[0] = 32'hA; rd_val[1] = 32'hB; rd_val[2] = 32'hC; rd_val[3] = 32'hD;
    issue_fw_read(); g = cyc;
    run(60, "t2_wait");
    tests++;
    if (done_who !== 1 || done_cyc - g !== 18 || done_err !== 1'b0) begin
      fails++; $display("FAIL t2_done: who=%0d lat=%0d err=%0b, required 1/18/0", done_who, done_cyc - g, done_err);
    end
    tests++;
    if (done_rd !== RPAY) begin fails++; $display("FAIL t2_rddata: got %h required %h", done_rd, RPAY); end
    tests++;
    if (n_ns !== 4 || ns_wr[0] !== 1'b0 || ns_addr[3] !== 32'h200C) begin
      fails++; $display("FAIL t2_nonseq: count=%0d wr=%0b addr3=%0h, required 4/0/200c", n_ns, ns_wr[0], ns_addr[3]);
    end
    ws = 0;
  endtask

  task automatic test_back_to_back();
    int g;
    rd_val[0] = 32'hA; rd_val[1] = 32'hB; rd_val[2] = 32'hC; rd_val[3] = 32'hD;
    issue_bc_write(); issue_fw_read(); g = cyc;
    run(40, "t3a_first");
    tests++;
    if (done_who !== 0 || done_cyc - g !== 10) begin
      fails++; $display("FAIL t3a_first: who=%0d lat=%0d, required 0/10", done_who, done_cyc - g);
    end
    run(40, "t3a_second");
    tests++;
    if (done_who !== 1 || done_cyc - g !== 20 || done_rd !== RPAY) begin
      fails++; $display("FAIL t3a_second: who=%0d lat=%0d rd=%h, required 1/20/%h", done_who, done_cyc - g, done_rd, RPAY);
    end
    // bc alone becomes the last served client, so the next tie must go to fw
    issue_bc_write();
    run(40, "t3b_bc_only");
    step();
    issue_bc_write(); issue_fw_read(); g = cyc;
    run(40, "t3c_first");
    tests++;
    if (done_who !== 1 || done_cyc - g !== 10) begin
      fails++; $display("FAIL t3c_first: who=%0d lat=%0d, required 1/10", done_who, done_cyc - g);
    end
    run(40, "t3c_second");
    tests++;
    if (done_who !== 0 || done_cyc - g !== 20) begin
      fails++; $display("FAIL t3c_second: who=%0d lat=%0d, required 0/20", done_who, done_cyc - g);
    end
  endtask

  task automatic test_error();
    int g;
    clear_log(); err_beat = 1;
    rd_val[0] = 32'hA1; rd_val[1] = 32'hB2; rd_val[2] = 32'hC3; rd_val[3] = 32'hD4;
    bc_bus_addr = 32'h3000; bc_bus_RW = 1'b0; bc_bus_go = 1'b1; g = cyc;
    run(40, "t4_wait");
    tests++;
    if (done_who !== 0 || done_cyc - g !== 7 || done_err !== 1'b1) begin
      fails++; $display("FAIL t4_done: who=%0d lat=%0d err=%0b, required 0/7/1", done_who, done_cyc - g, done_err);
    end
    tests++;
    if (done_rd !== 128'h000000A1) begin fails++; $display("FAIL t4_rddata: got %h required %h", done_rd, 128'h000000A1); end
    tests++;
    if (n_ns !== 2) begin fails++; $display("FAIL t4_nonseq: count=%0d, required 2", n_ns); end
    err_beat = -1;
  endtask

  task automatic test_timeout();
    int g;
    clear_log(); stall = 1;
    bc_bus_addr = 32'h4000; bc_bus_RW = 1'b1; bc_bus_write = WPAY; bc_bus_go = 1'b1; g = cyc;
    run(300, "t5_wait");
    tests++;
    if (done_who !== 0 || done_cyc - g !== 258 || done_err !== 1'b1) begin
      fails++; $display("FAIL t5_done: who=%0d lat=%0d err=%0b, required 0/258/1", done_who, done_cyc - g, done_err);
    end
    stall = 0;
    step();
    tests++;
    if (O_htrans !== 2'b00 || O_haddr !== 32'h0) begin
      fails++; $display("FAIL t5_idle: htrans=%0h haddr=%0h, required 0/0", O_htrans, O_haddr);
    end
    clear_log();
    issue_bc_write(); g = cyc;
    run(40, "t5_next_wait");
    check_write_txn(g, "t5_next");
  endtask

  task automatic test_reset_mid();
    int g;
    clear_log();
    issue_bc_write(); g = cyc;
    got_done = 0;
    repeat (6) step();
    tests++;
    if (O_htrans !== 2'b10 || O_haddr !== 32'h1008) begin
      fails++; $display("FAIL t6_beat2: htrans=%0h haddr=%0h, required 2/1008", O_htrans, O_haddr);
    end
    rst_n = 1'b0;
    dph = 0;
    #1;
    tests++;
    if (O_htrans !== 2'b00 || O_haddr !== 32'h0 || O_hwrite !== 1'b0 || O_hprot !== 4'h0 || O_hsize !== 3'h0) begin
      fails++; $display("FAIL t6_async: htrans=%0h haddr=%0h hwrite=%0b hprot=%0h hsize=%0h, required 0", O_htrans, O_haddr, O_hwrite, O_hprot, O_hsize);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    tests++;
    if (got_done !== 0) begin fails++; $display("FAIL t6_no_done: done seen at cycle %0d, required none", done_cyc); end
    clear_log();
    issue_bc_write(); g = cyc;
    run(40, "t6_after_wait");
    check_write_txn(g, "t6_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) rd_val[k] = '0;
    clear_log();
    test_reset();
    test_bc_write();
    step();
    test_fw_read_wait();
    step();
    test_back_to_back();
    step();
    test_error();
    step();
    test_timeout();
    step();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
